// File: rtl/final_project_soc_pio_pkg.sv
// Shared constants for the status-input PIO: register word addresses and edge-type encodings.
package final_project_soc_pio_pkg;

    typedef enum logic [1:0] {
        AddrData     = 2'd0,
        AddrReserved = 2'd1,
        AddrIrqMask  = 2'd2,
        AddrEdgeCap  = 2'd3
    } pio_addr_e;

    localparam int unsigned EdgeRise = 0;
    localparam int unsigned EdgeFall = 1;
    localparam int unsigned EdgeAny  = 2;

endpackage

// File: rtl/final_project_soc_pio_edge_detect.sv
// Two-flop input synchronizer plus per-bit edge-event generation.
// Edge logic exists only when FINAL_PROJECT_SOC_STATUS_IN_IRQ_EN is defined.
module final_project_soc_pio_edge_detect
    import final_project_soc_pio_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned EDGE_TYPE = EdgeRise
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_in_port,
`ifdef FINAL_PROJECT_SOC_STATUS_IN_IRQ_EN
    output logic [WIDTH-1:0] o_edge,
`endif
    output logic [WIDTH-1:0] o_data_in
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_data_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= '0;
            r_data_in <= '0;
        end else begin
            r_sync1   <= i_in_port;
            r_data_in <= r_sync1;
        end
    end

    assign o_data_in = r_data_in;

`ifdef FINAL_PROJECT_SOC_STATUS_IN_IRQ_EN
    logic [WIDTH-1:0] r_data_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_prev <= '0;
        end else begin
            r_data_prev <= r_data_in;
        end
    end

    // Unrecognised EDGE_TYPE values fall back to any-edge.
    generate
        if (EDGE_TYPE == EdgeRise) begin : g_rise
            assign o_edge = r_data_in & ~r_data_prev;
        end else if (EDGE_TYPE == EdgeFall) begin : g_fall
            assign o_edge = ~r_data_in & r_data_prev;
        end else begin : g_any
            assign o_edge = r_data_in ^ r_data_prev;
        end
    endgenerate
`else
    logic w_unused_edge_type;
    assign w_unused_edge_type = (EDGE_TYPE == EdgeAny);
`endif

endmodule

// File: rtl/final_project_soc_status_in.sv
// Avalon-MM status-input PIO: synchronized input read, optional sticky edge capture and level IRQ.
// Optional feature macro: FINAL_PROJECT_SOC_STATUS_IN_IRQ_EN (irq_mask / edge_capture / irq).
module final_project_soc_status_in
    import final_project_soc_pio_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned EDGE_TYPE = EdgeRise
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_data_in;
    logic [31:0]      w_rdata;
    logic [31:0]      r_readdata;
    logic             w_unused_bus;

    assign w_unused_bus = ^{chipselect, write_n, writedata};

`ifdef FINAL_PROJECT_SOC_STATUS_IN_IRQ_EN
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clear;
    logic [WIDTH-1:0] w_edge_capture_d;
    logic [WIDTH-1:0] r_edge_capture;
    logic [WIDTH-1:0] r_irq_mask;
    logic             r_irq;
    logic             w_wr;

    final_project_soc_pio_edge_detect #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_edge_detect (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_in_port (in_port),
        .o_edge    (w_edge),
        .o_data_in (w_data_in)
    );

    assign w_wr = chipselect & ~write_n;

    // New edge events are OR-ed in after the clear so a coincident event wins.
    always_comb begin
        w_clear = '0;
        if (w_wr && (address == AddrEdgeCap)) begin
            w_clear = writedata[WIDTH-1:0];
        end
        w_edge_capture_d = (r_edge_capture & ~w_clear) | w_edge;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask     <= '0;
            r_edge_capture <= '0;
            r_irq          <= 1'b0;
        end else begin
            if (w_wr && (address == AddrIrqMask)) begin
                r_irq_mask <= writedata[WIDTH-1:0];
            end
            r_edge_capture <= w_edge_capture_d;
            r_irq          <= |(r_edge_capture & r_irq_mask);
        end
    end

    assign irq = r_irq;
`else
    final_project_soc_pio_edge_detect #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_edge_detect (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_in_port (in_port),
        .o_data_in (w_data_in)
    );

    assign irq = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        case (address)
            AddrData:    w_rdata[WIDTH-1:0] = w_data_in;
`ifdef FINAL_PROJECT_SOC_STATUS_IN_IRQ_EN
            AddrIrqMask: w_rdata[WIDTH-1:0] = r_irq_mask;
            AddrEdgeCap: w_rdata[WIDTH-1:0] = r_edge_capture;
`endif
            default:     w_rdata = '0;
        endcase
    end

    // Read port is free-running: it samples the addressed register every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rdata;
        end
    end

    assign readdata = r_readdata;

endmodule

// File: tb/tb_final_project_soc_status_in.sv
// Directed self-checking bench for final_project_soc_status_in (WIDTH=8, rising edge).
// With FINAL_PROJECT_SOC_STATUS_IN_IRQ_EN defined, a second any-edge instance is also exercised.
module tb_final_project_soc_status_in;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [7:0]  in_port = 8'h00;
    logic [31:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    final_project_soc_status_in #(
        .WIDTH     (8),
        .EDGE_TYPE (0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

`ifdef FINAL_PROJECT_SOC_STATUS_IN_IRQ_EN
    logic [7:0]  in_port2 = 8'h00;
    logic [31:0] readdata2;
    logic        irq2;

    final_project_soc_status_in #(
        .WIDTH     (8),
        .EDGE_TYPE (2)
    ) dut_any (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port2),
        .readdata   (readdata2),
        .irq        (irq2)
    );
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a read address; returns 1 ns after the edge that registers readdata.
    task automatic rd(input logic [1:0] a);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Single-cycle write; returns 1 ns after the edge that performs it.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(posedge clk);
        #1;
        write_n    = 1'b1;
        chipselect = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [7:0] v);
        @(negedge clk);
        in_port = v;
    endtask

    initial begin
        #1;
        check_eq("rst_readdata", readdata, 32'h0);
        check_eq("rst_irq", {31'h0, irq}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Input-to-readdata latency: sync(2) + read register(1).
        set_in(8'hA5);
        tick(1);
        check_eq("lat_edge1", readdata, 32'h0);
        tick(1);
        check_eq("lat_edge2", readdata, 32'h0);
        tick(1);
        check_eq("lat_edge3", readdata, 32'h0000_00A5);

        wr(2'd0, 32'h0000_0055);
        rd(2'd0);
        check_eq("addr0_write_ignored", readdata, 32'h0000_00A5);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1);
        check_eq("addr1_reads_zero", readdata, 32'h0);
        check_eq("irq_idle", {31'h0, irq}, 32'h0);

`ifdef FINAL_PROJECT_SOC_STATUS_IN_IRQ_EN
        set_in(8'h00);
        tick(4);
        wr(2'd3, 32'h0000_00FF);
        rd(2'd3);
        check_eq("cap_cleared", readdata, 32'h0);

        set_in(8'h05);
        tick(3);
        rd(2'd0);
        check_eq("data_05", readdata, 32'h0000_0005);
        rd(2'd3);
        check_eq("cap_05", readdata, 32'h0000_0005);
        check_eq("irq_masked", {31'h0, irq}, 32'h0);
        rd(2'd3);
        check_eq("any_cap_idle", readdata2, 32'h0);

        wr(2'd2, 32'h0000_0004);
        check_eq("irq_before_reg", {31'h0, irq}, 32'h0);
        tick(1);
        check_eq("irq_unmasked", {31'h0, irq}, 32'h1);
        check_eq("irq2_no_cap", {31'h0, irq2}, 32'h0);
        rd(2'd2);
        check_eq("mask_rb", readdata, 32'h0000_0004);

        wr(2'd3, 32'h0000_0004);
        tick(1);
        check_eq("irq_after_clear", {31'h0, irq}, 32'h0);
        rd(2'd3);
        check_eq("cap_after_clear", readdata, 32'h0000_0001);

        // Bit-1 event reaches edge_capture on the same edge as its clear.
        set_in(8'h07);
        @(posedge clk);
        @(posedge clk);
        wr(2'd3, 32'h0000_0002);
        rd(2'd3);
        check_eq("set_beats_clear", readdata, 32'h0000_0003);
        check_eq("irq_bit2_clear", {31'h0, irq}, 32'h0);

        wr(2'd3, 32'h0000_00FF);
        @(negedge clk);
        in_port2 = 8'h01;
        tick(3);
        rd(2'd3);
        check_eq("any_rise_cap", readdata2, 32'h0000_0001);
        check_eq("rise_cap_cleared", readdata, 32'h0);
        wr(2'd3, 32'h0000_0001);
        rd(2'd3);
        check_eq("any_cap_clear", readdata2, 32'h0);
        @(negedge clk);
        in_port2 = 8'h00;
        tick(3);
        rd(2'd3);
        check_eq("any_fall_cap", readdata2, 32'h0000_0001);
        rd(2'd1);
        check_eq("any_addr1_zero", readdata2, 32'h0);

        set_in(8'h00);
        tick(4);
        wr(2'd3, 32'h0000_00FF);
        set_in(8'h3C);
        tick(4);
        wr(2'd2, 32'h0000_00FF);
        tick(2);
        check_eq("irq_pre_reset", {31'h0, irq}, 32'h1);
        rd(2'd3);
        check_eq("cap_3c", readdata, 32'h0000_003C);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_irq", {31'h0, irq}, 32'h0);
        check_eq("async_rst_readdata", readdata, 32'h0);
        check_eq("async_rst_readdata2", readdata2, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd3);
        check_eq("post_rst_cap", readdata, 32'h0);
        rd(2'd2);
        check_eq("post_rst_mask", readdata, 32'h0);
        check_eq("post_rst_irq", {31'h0, irq}, 32'h0);
`else
        wr(2'd2, 32'h0000_00FF);
        rd(2'd2);
        check_eq("noirq_addr2", readdata, 32'h0);
        rd(2'd3);
        check_eq("noirq_addr3", readdata, 32'h0);
        check_eq("noirq_irq0", {31'h0, irq}, 32'h0);

        set_in(8'h5A);
        tick(3);
        rd(2'd0);
        check_eq("noirq_data_5a", readdata, 32'h0000_005A);
        rd(2'd2);
        check_eq("noirq_addr2_b", readdata, 32'h0);
        rd(2'd3);
        check_eq("noirq_addr3_b", readdata, 32'h0);
        check_eq("noirq_irq1", {31'h0, irq}, 32'h0);

        set_in(8'hFF);
        tick(3);
        rd(2'd0);
        check_eq("noirq_data_ff", readdata, 32'h0000_00FF);
        check_eq("noirq_irq2", {31'h0, irq}, 32'h0);

        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_readdata", readdata, 32'h0);
        check_eq("async_rst_irq", {31'h0, irq}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd0);
        check_eq("post_rst_sync", readdata, 32'h0);
        rd(2'd0);
        check_eq("post_rst_data", readdata, 32'h0000_00FF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/final_project_soc_status_in.md
FINAL_PROJECT_SOC_STATUS_IN -- requirements
Module: final_project_soc_status_in

Interface
REQ-001 Parameter WIDTH, default 8: number of input port bits (1..32).
REQ-002 Parameter EDGE_TYPE, default 0: edge capture type; 0 = rising, 1 = falling, 2 = any.
REQ-003 clk  input  1: single clock; all logic synchronous to its rising edge.
REQ-004 reset_n  input  1: asynchronous active-low reset.
REQ-005 address  input  2: Avalon-MM slave word address.
REQ-006 chipselect  input  1: slave select.
REQ-007 write_n  input  1: active-low write strobe, qualified by chipselect.
REQ-008 writedata  input  32: write data.
REQ-009 in_port  input  WIDTH: asynchronous status inputs from the graphics pipeline.
REQ-010 readdata  output  32: read data, registered.
REQ-011 irq  output  1: level interrupt request, active high.

Function
REQ-012 in_port SHALL pass through a 2-flop synchronizer; the second stage is "data_in".
REQ-013 A third register "data_prev" SHALL hold the previous data_in for edge detection.
REQ-014 Edge event per bit: rising = data_in & ~data_prev; falling = ~data_in & data_prev; any = XOR, selected by EDGE_TYPE.
REQ-015 Register map: 0 = data_in (RO); 1 = reads 0, writes ignored; 2 = irq_mask (RW, WIDTH bits); 3 = edge_capture (R, write-1-to-clear).
REQ-016 Read latency SHALL be 1 cycle: readdata updates on the clock edge after the address is presented, every cycle regardless of chipselect; unused upper bits are 0.
REQ-017 Write SHALL occur when chipselect && ~write_n; writes to address 0 are ignored.
REQ-018 Writing address 3 SHALL clear each edge_capture bit whose writedata bit is 1; other bits are held.
REQ-019 An edge event on a bit SHALL set its edge_capture bit on the next clock, sticky until cleared.
REQ-020 Simultaneous edge event and clear on the same bit: set SHALL win.
REQ-021 irq SHALL equal |(edge_capture & irq_mask), registered, asserted 1 cycle after edge_capture sets.
REQ-022 Edge-to-edge_capture latency from in_port change: 3 clocks (2 sync + detect).
REQ-023 Writing irq_mask SHALL NOT modify edge_capture; unmasking a pending bit asserts irq on the next clock.

Reset
REQ-024 On reset_n low, synchronizer, data_prev, irq_mask, edge_capture, readdata and irq SHALL clear to 0 immediately.
REQ-025 After reset release, no edge SHALL be reported for inputs already high at release until data_prev has tracked data_in for one cycle (data_prev reset to 0 with rising type MAY capture one edge; this is accepted and documented).

Configuration
REQ-026 Macro FINAL_PROJECT_SOC_STATUS_IN_IRQ_EN defined: irq_mask, edge_capture and irq logic SHALL be present per REQ-013..023.
REQ-027 Macro undefined: addresses 2 and 3 SHALL read 0, writes ignored, irq tied to 0, data_prev and edge logic omitted; data read path unchanged.

Structure
REQ-028 Shared package final_project_soc_pio_pkg SHALL hold register address constants (data, reserved, irq_mask, edge_capture) and the EDGE_TYPE encoding constants.
REQ-029 One sub-module final_project_soc_pio_edge_detect SHALL contain the synchronizer, data_prev and edge-event generation; the top holds registers, read mux and irq.

Verification
REQ-030 WIDTH=8, rising: in_port 0x00->0x05; read addr 0 after 3 clocks -> 0x05; read addr 3 -> 0x05; irq stays 0 (mask 0).
REQ-031 Write addr 2 = 0x04 with edge_capture = 0x05 -> irq = 1 next clock; write addr 3 = 0x04 -> edge_capture 0x01, irq = 0 next clock.
REQ-032 Rising edge on bit 1 in the same cycle as a write addr 3 = 0x02 -> edge_capture bit 1 remains 1.
REQ-033 EDGE_TYPE=2, bit 0 toggles 0->1->0 with a clear between -> each transition sets edge_capture[0]; reads of addr 1 -> 0x00000000.
REQ-034 Assert reset_n low mid-operation with mask 0xFF, edge_capture 0x3C, irq 1 -> irq, readdata, mask, capture all 0 immediately without a clock.
REQ-035 Build without FINAL_PROJECT_SOC_STATUS_IN_IRQ_EN: toggle in_port, write addr 2 = 0xFF -> addr 2/3 read 0, irq stays 0, addr 0 tracks in_port.
